// File: rtl/wb_ext_ram_arbiter_if.sv
// Bus bundle for wb_ext_ram_arbiter: both Wishbone masters plus the external RAM port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_ext_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DATA_WIDTH-1:0] m0_dat_i, m1_dat_i, s_dat_o;
    logic [SEL_WIDTH-1:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic                  m0_we_i, m0_cyc_i, m0_stb_i;
    logic                  m1_we_i, m1_cyc_i, m1_stb_i;
    logic                  s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]            m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]            m0_bte_i, m1_bte_i, s_bte_o;
    logic [DATA_WIDTH-1:0] m0_dat_o, m1_dat_o, s_dat_i;
    logic                  m0_ack_o, m0_err_o, m0_rty_o;
    logic                  m1_ack_o, m1_err_o, m1_rty_o;
    logic                  s_ack_i, s_err_i, s_rty_i;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_cti_i, m0_bte_i,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_cti_i, m1_bte_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_cti_i, m0_bte_i,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_cti_i, m1_bte_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
    );
endinterface

// File: rtl/wb_ext_ram_arbiter.sv
// Round-robin two-master Wishbone arbiter for the external RAM; the grant is held for a whole cyc.
// Define WB_EXT_ARB_TIMEOUT_EN to add the stalled-slave watchdog (ABORT state, timeout_o pulse).
module wb_ext_ram_arbiter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_sys_n,
    wb_ext_ram_arbiter_if.slave       bus,
    output logic [1:0]                grant_o,
    output logic                      timeout_o
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_ext_ram_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

`ifdef WB_EXT_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10, ABORT = 2'b11} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
`endif

    state_t     state_r;
    logic       last_r;
    logic [1:0] grant_r;
    logic       own_cyc_s;
    logic       own_stb_s;
    logic       oth_cyc_s;
    logic       tmo_hit_s;

    // Owner is taken from the registered grant so the ABORT state still knows who holds cyc.
    always_comb begin
        own_cyc_s = 1'b0;
        own_stb_s = 1'b0;
        oth_cyc_s = 1'b0;
        if (grant_r[1]) begin
            own_cyc_s = bus.m1_cyc_i;
            own_stb_s = bus.m1_stb_i;
            oth_cyc_s = bus.m0_cyc_i;
        end else begin
            own_cyc_s = bus.m0_cyc_i;
            own_stb_s = bus.m0_stb_i;
            oth_cyc_s = bus.m1_cyc_i;
        end
    end

`ifdef WB_EXT_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_r;

    // Stall counter: restarts on grant change or termination, advances while stb waits.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt_r <= 16'd0;
        end else if (!(((state_r == GNT0) || (state_r == GNT1)) && own_cyc_s)) begin
            cnt_r <= 16'd0;
        end else if (bus.s_ack_i || bus.s_err_i || bus.s_rty_i) begin
            cnt_r <= 16'd0;
        end else if (own_stb_s) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Watchdog fires from registered state only, so the abort pulse lasts exactly one cycle.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (((state_r == GNT0) || (state_r == GNT1)) && own_cyc_s && (cnt_r == TMO_LIMIT)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end
`else
    // Without the watchdog a stalled slave simply keeps the grant.
    always_comb begin
        tmo_hit_s = own_stb_s & 1'b0;
    end
`endif

    assign timeout_o = tmo_hit_s;
    assign grant_o   = grant_r;

    // Arbitration FSM: state, round-robin pointer and one-hot grant move together.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            grant_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_r)) begin
                        state_r <= GNT0;
                        grant_r <= 2'b01;
                    end else if (bus.m1_cyc_i) begin
                        state_r <= GNT1;
                        grant_r <= 2'b10;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= 2'b00;
                    end
                end
`ifdef WB_EXT_ARB_TIMEOUT_EN
                GNT0, GNT1, ABORT: begin
`else
                GNT0, GNT1: begin
`endif
                    if (!own_cyc_s) begin
                        last_r <= grant_r[1];
                        if (oth_cyc_s) begin
                            state_r <= grant_r[1] ? GNT0 : GNT1;
                            grant_r <= grant_r[1] ? 2'b01 : 2'b10;
                        end else begin
                            state_r <= IDLE;
                            grant_r <= 2'b00;
                        end
`ifdef WB_EXT_ARB_TIMEOUT_EN
                    end else if (tmo_hit_s) begin
                        state_r <= ABORT;
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 2'b00;
                end
            endcase
        end
    end

    // Zero-latency pass-through for the owner; everyone else sees an idle, unterminated bus.
    always_comb begin
        bus.s_adr_o  = '0;
        bus.s_dat_o  = '0;
        bus.s_sel_o  = '0;
        bus.s_we_o   = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_cti_o  = 3'b000;
        bus.s_bte_o  = 2'b00;
        bus.m0_dat_o = '0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_rty_o = 1'b0;
        bus.m1_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_rty_o = 1'b0;
        case (state_r)
            GNT0: begin
                if (tmo_hit_s) begin
                    bus.m0_err_o = 1'b1;
                end else begin
                    bus.s_adr_o  = bus.m0_adr_i;
                    bus.s_dat_o  = bus.m0_dat_i;
                    bus.s_sel_o  = bus.m0_sel_i;
                    bus.s_we_o   = bus.m0_we_i;
                    bus.s_cyc_o  = bus.m0_cyc_i;
                    bus.s_stb_o  = bus.m0_stb_i;
                    bus.s_cti_o  = bus.m0_cti_i;
                    bus.s_bte_o  = bus.m0_bte_i;
                    bus.m0_dat_o = bus.s_dat_i;
                    bus.m0_ack_o = bus.s_ack_i;
                    bus.m0_err_o = bus.s_err_i;
                    bus.m0_rty_o = bus.s_rty_i;
                end
            end
            GNT1: begin
                if (tmo_hit_s) begin
                    bus.m1_err_o = 1'b1;
                end else begin
                    bus.s_adr_o  = bus.m1_adr_i;
                    bus.s_dat_o  = bus.m1_dat_i;
                    bus.s_sel_o  = bus.m1_sel_i;
                    bus.s_we_o   = bus.m1_we_i;
                    bus.s_cyc_o  = bus.m1_cyc_i;
                    bus.s_stb_o  = bus.m1_stb_i;
                    bus.s_cti_o  = bus.m1_cti_i;
                    bus.s_bte_o  = bus.m1_bte_i;
                    bus.m1_dat_o = bus.s_dat_i;
                    bus.m1_ack_o = bus.s_ack_i;
                    bus.m1_err_o = bus.s_err_i;
                    bus.m1_rty_o = bus.s_rty_i;
                end
            end
            default: begin
                bus.s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule
